// File: rtl/vec_out_drain.sv
// Result drain for the tile-engine multiplier: captures the whole result array in one
// handshake, optionally applies ReLU, then streams it out one element per cycle.
//
// state  | meaning
// IDLE   | buffer empty, in_ready high, waiting for a result array
// STREAM | buffer holds a captured array, emitting elements vector-major
module vec_out_drain #(
    parameter int TILE_ENG = 2,
    parameter int MAT_R    = 8,
    parameter int OUT_BITS = 4,
    parameter int VI_W     = (TILE_ENG > 1 ? $clog2(TILE_ENG) : 1),
    parameter int EI_W     = (MAT_R > 1 ? $clog2(MAT_R) : 1)
) (
    input  logic                                               clock,
    input  logic                                               reset,
    input  logic                                               in_valid,
    output logic                                               in_ready,
    input  logic signed [TILE_ENG-1:0][MAT_R-1:0][OUT_BITS-1:0] in_vecs,
    input  logic                                               relu_en,
    output logic                                               out_valid,
    input  logic                                               out_ready,
    output logic signed [OUT_BITS-1:0]                         out_data,
    output logic [VI_W-1:0]                                    out_vec_idx,
    output logic [EI_W-1:0]                                    out_elem_idx,
    output logic                                               out_last_elem,
    output logic                                               out_last,
    output logic                                               busy
);

    typedef enum logic {IDLE, STREAM} state_t;

    state_t                     state_r, state_nx;
    logic [VI_W-1:0]            vi_r;
    logic [EI_W-1:0]            ei_r;
    logic signed [OUT_BITS-1:0] elem_buf [TILE_ENG][MAT_R];
    logic                       capture;
    logic                       handshake;
    logic                       ei_max;
    logic                       vi_max;

    assign ei_max    = (ei_r == EI_W'(MAT_R - 1));
    assign vi_max    = (vi_r == VI_W'(TILE_ENG - 1));
    assign capture   = in_valid && in_ready;
    assign handshake = out_valid && out_ready;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nx;
        end
    end

    always_comb begin
        state_nx = state_r;
        case (state_r)
            IDLE:   if (capture) state_nx = STREAM;
            STREAM: if (handshake && out_last) state_nx = capture ? STREAM : IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // A capture (idle or back-to-back) always restarts the walk at (0,0).
    always_ff @(posedge clock) begin
        if (reset) begin
            vi_r <= '0;
            ei_r <= '0;
        end else if (capture || (handshake && out_last)) begin
            vi_r <= '0;
            ei_r <= '0;
        end else if (handshake) begin
            if (ei_max) begin
                ei_r <= '0;
                vi_r <= vi_r + 1'b1;
            end else begin
                ei_r <= ei_r + 1'b1;
            end
        end
    end

    // Negative test uses the sign bit so the most-negative code clamps like any other.
    always_ff @(posedge clock) begin
        if (capture) begin
            for (int v = 0; v < TILE_ENG; v++) begin
                for (int e = 0; e < MAT_R; e++) begin
                    elem_buf[v][e] <= (relu_en && in_vecs[v][e][OUT_BITS-1]) ? '0 : in_vecs[v][e];
                end
            end
        end
    end

    always_comb begin
        out_valid     = 1'b0;
        busy          = 1'b0;
        out_data      = '0;
        out_last_elem = 1'b0;
        out_last      = 1'b0;
        in_ready      = 1'b0;
        out_vec_idx   = vi_r;
        out_elem_idx  = ei_r;
        if (state_r == STREAM) begin
            out_valid     = 1'b1;
            busy          = 1'b1;
            out_data      = elem_buf[vi_r][ei_r];
            out_last_elem = ei_max;
            out_last      = ei_max && vi_max;
            in_ready      = !reset && out_ready && ei_max && vi_max;
        end else begin
            in_ready      = !reset;
        end
    end

endmodule

// File: tb/tb_vec_out_drain.sv
// Directed bench for vec_out_drain: a queue of expected beats is filled at each capture
// and every streamed cycle is compared against its head.
module tb_vec_out_drain;

    logic                            clock = 1'b0;
    logic                            reset;
    logic                            in_valid;
    logic                            in_ready;
    logic signed [1:0][7:0][3:0]     in_vecs;
    logic                            relu_en;
    logic                            out_valid;
    logic                            out_ready;
    logic signed [3:0]               out_data;
    logic [0:0]                      out_vec_idx;
    logic [2:0]                      out_elem_idx;
    logic                            out_last_elem;
    logic                            out_last;
    logic                            busy;

    logic [3:0] arr [2][8];

    typedef struct packed {
        logic [3:0] d;
        logic       vi;
        logic [2:0] ei;
        logic       le;
        logic       l;
    } beat_t;

    beat_t q[$];
    int    total  = 0;
    int    passed = 0;
    int    beats  = 0;

    vec_out_drain dut (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_vecs(in_vecs), .relu_en(relu_en), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_vec_idx(out_vec_idx), .out_elem_idx(out_elem_idx),
        .out_last_elem(out_last_elem), .out_last(out_last), .busy(busy)
    );

    always #5 clock = ~clock;

    always_comb begin
        for (int v = 0; v < 2; v++)
            for (int e = 0; e < 8; e++)
                in_vecs[v][e] = arr[v][e];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    task automatic push_expected();
        beat_t b;
        for (int v = 0; v < 2; v++) begin
            for (int e = 0; e < 8; e++) begin
                b.d  = (relu_en && arr[v][e][3]) ? 4'd0 : arr[v][e];
                b.vi = v[0];
                b.ei = e[2:0];
                b.le = (e == 7);
                b.l  = (e == 7) && (v == 1);
                q.push_back(b);
            end
        end
    endtask

    // Called at a negedge with inputs already set; returns at the following negedge.
    task automatic tick(input bit do_chk);
        beat_t b;
        logic  exp_ir;
        bit    hs, cap, rs;
        #1;
        if (reset)             exp_ir = 1'b0;
        else if (q.size() == 0) exp_ir = 1'b1;
        else                   exp_ir = out_ready && q[0].l;
        if (do_chk) begin
            chk("in_ready", {31'd0, in_ready}, {31'd0, exp_ir});
            chk("busy", {31'd0, busy}, {31'd0, q.size() != 0});
            chk("out_valid", {31'd0, out_valid}, {31'd0, q.size() != 0});
            if (q.size() != 0) begin
                b = q[0];
                chk("out_data", {28'd0, out_data}, {28'd0, b.d});
                chk("out_vec_idx", {31'd0, out_vec_idx}, {31'd0, b.vi});
                chk("out_elem_idx", {29'd0, out_elem_idx}, {29'd0, b.ei});
                chk("out_last_elem", {31'd0, out_last_elem}, {31'd0, b.le});
                chk("out_last", {31'd0, out_last}, {31'd0, b.l});
            end else begin
                chk("idle_data", {28'd0, out_data}, 32'd0);
                chk("idle_vec_idx", {31'd0, out_vec_idx}, 32'd0);
                chk("idle_elem_idx", {29'd0, out_elem_idx}, 32'd0);
            end
        end
        hs  = (q.size() != 0) && out_ready;
        cap = in_valid && exp_ir;
        rs  = reset;
        @(posedge clock);
        if (rs) begin
            q.delete();
        end else begin
            if (hs) begin
                void'(q.pop_front());
                beats++;
            end
            if (cap) push_expected();
        end
        @(negedge clock);
    endtask

    task automatic load(input bit r);
        relu_en   = r;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        tick(1);
        in_valid  = 1'b0;
    endtask

    task automatic drain(input bit bp);
        int         g;
        logic [3:0] pat;
        g   = 0;
        pat = 4'b1001;
        while (q.size() != 0 && g < 200) begin
            out_ready = bp ? pat[g % 4] : 1'b1;
            tick(1);
            g++;
        end
        out_ready = 1'b1;
        chk("drain_done", q.size(), 0);
    endtask

    task automatic fill_all(input logic [3:0] val);
        for (int v = 0; v < 2; v++)
            for (int e = 0; e < 8; e++)
                arr[v][e] = val;
    endtask

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        relu_en   = 1'b0;
        out_ready = 1'b1;
        fill_all(4'd0);

        // reset for two cycles, then idle
        tick(0);
        tick(1);
        reset = 1'b0;
        tick(1);

        // basic stream
        for (int v = 0; v < 2; v++)
            for (int e = 0; e < 8; e++)
                arr[v][e] = 4'(v * 8 + e - 8);
        beats = 0;
        load(0);
        drain(0);
        chk("basic_beats", beats, 16);
        tick(1);

        // ReLU clamps, then pass-through with relu off
        fill_all(4'hD); load(1); drain(0);
        fill_all(4'h8); load(1); drain(0);
        fill_all(4'hD); load(0); drain(0);
        fill_all(4'h8); load(0); drain(0);
        tick(1);

        // backpressure 1,0,0,1
        for (int v = 0; v < 2; v++)
            for (int e = 0; e < 8; e++)
                arr[v][e] = 4'(e + 3 * v);
        beats = 0;
        load(0);
        drain(1);
        chk("bp_beats", beats, 16);
        tick(1);

        // back-to-back capture on the final beat
        for (int v = 0; v < 2; v++)
            for (int e = 0; e < 8; e++)
                arr[v][e] = 4'(v * 8 + e);
        beats = 0;
        load(0);
        fill_all(4'd7);
        while (q.size() > 1 && beats < 40) tick(1);
        fill_all(4'd5);
        in_valid = 1'b1;
        tick(1);
        in_valid = 1'b0;
        chk("b2b_captured", q.size(), 16);
        fill_all(4'd1);
        drain(0);
        chk("b2b_beats", beats, 32);
        tick(1);

        // reset after five handshakes
        fill_all(4'd2);
        beats = 0;
        load(0);
        while (beats < 5 && q.size() != 0) tick(1);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        tick(1);
        for (int v = 0; v < 2; v++)
            for (int e = 0; e < 8; e++)
                arr[v][e] = 4'(7 - e - v);
        beats = 0;
        load(0);
        drain(0);
        chk("restart_beats", beats, 16);
        tick(1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
